// File: rtl/phase_sequencer.sv
// Run/pause sequencer stepping a five-phase instruction cycle from a debounced push-button.
// Short instructions (ST, taken-branch forms, CMP, OUT) finish at P4; HLT stops the block at P2.
module phase_sequencer #(
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_btn,
    input  logic        step_mode,
    input  logic [15:0] instruction,
    output logic [2:0]  phase,
    output logic        exec,
    output logic        halted,
    output logic        instr_done,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

    localparam logic [7:0] DbLast = 8'(DEBOUNCE - 1);

    logic        sync1_q, sync2_q;
    logic        stable_q, stable_d;
    logic [7:0]  db_cnt_q, db_cnt_d;
    logic        press_q, press_d;

    state_e      state_q, state_d;
    logic [2:0]  phase_q, phase_d;
    logic        pause_q, pause_d;
    logic [15:0] instr_count_q, instr_count_d;

    logic [1:0]  op;
    logic        short_instr;
    logic        is_hlt;
    logic [2:0]  last_phase;
    logic        at_last;
    logic        unused_ir_bits;

    // Button path: synchronizer, then a run-length debouncer on the synchronized level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            db_cnt_q <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= start_btn;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            db_cnt_q <= db_cnt_d;
            press_q  <= press_d;
        end
    end

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (sync2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DbLast) begin
            stable_d = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 8'd1;
        end
        press_d = stable_d & ~stable_q;
    end

    assign op             = instruction[15:14];
    assign unused_ir_bits = ^{instruction[10:8], instruction[3:0]};

    always_comb begin
        short_instr = (op == 2'b01)
                    || (op == 2'b10 && (instruction[13:11] == 3'b100
                                        || instruction[13:11] == 3'b111))
                    || (op == 2'b11 && (instruction[7:4] == 4'b0101
                                        || instruction[7:4] == 4'b1101));
        is_hlt      = (op == 2'b11) && (instruction[7:4] == 4'b1111);
        last_phase  = short_instr ? 3'd4 : 3'd5;
        at_last     = (state_q == StRun) && (phase_q == last_phase);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            phase_q       <= 3'd0;
            pause_q       <= 1'b0;
            instr_count_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            pause_q       <= pause_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        pause_d       = pause_q;
        instr_count_d = instr_count_q;
        unique case (state_q)
            StIdle: begin
                if (press_q) begin
                    state_d = StRun;
                    phase_d = 3'd1;
                    pause_d = 1'b0;
                end
            end
            StRun: begin
                if (phase_q == 3'd2 && is_hlt) begin
                    state_d = StHalted;
                    phase_d = 3'd0;
                    pause_d = 1'b0;
                end else if (at_last) begin
                    instr_count_d = instr_count_q + 16'd1;
                    // A press landing exactly on the last phase pauses just like a pending one.
                    if (pause_q || press_q || step_mode) begin
                        state_d = StIdle;
                        phase_d = 3'd0;
                        pause_d = 1'b0;
                    end else begin
                        phase_d = 3'd1;
                    end
                end else begin
                    phase_d = phase_q + 3'd1;
                    if (press_q) begin
                        pause_d = 1'b1;
                    end
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
                phase_d = 3'd0;
                pause_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        phase       = phase_q;
        exec        = (phase_q != 3'd0);
        halted      = (state_q == StHalted);
        instr_done  = at_last & ~rst;
        instr_count = instr_count_q;
    end

endmodule
